// File: rtl/shape_processor_bank_pkg.sv
// Shared types, field positions and legality rules for the shape processor register bank.
package shape_processor_bank_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIELD_W    = 3;
  localparam int unsigned SHAPE_LSB  = 0;
  localparam int unsigned OP_LSB     = 4;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned STICKY_LSB = 16;

  typedef enum logic [FIELD_W-1:0] {
    SHAPE_CIRCLE    = 3'd0,
    SHAPE_RECTANGLE = 3'd1,
    SHAPE_TRIANGLE  = 3'd2,
    SHAPE_KEEP      = 3'd7
  } shape_e;

  typedef enum logic [FIELD_W-1:0] {
    OP_PERIMETER      = 3'd0,
    OP_AREA           = 3'd1,
    OP_IS_SQUARE      = 3'd2,
    OP_IS_EQUILATERAL = 3'd3,
    OP_IS_ISOSCELES   = 3'd4,
    OP_KEEP           = 3'd7
  } operation_e;

  typedef struct packed {
    logic [FIELD_W-1:0] operation;
    logic [FIELD_W-1:0] shape;
  } ctrl_t;

  function automatic logic is_legal_shape(input logic [FIELD_W-1:0] s);
    return (s == SHAPE_CIRCLE) || (s == SHAPE_RECTANGLE) ||
           (s == SHAPE_TRIANGLE) || (s == SHAPE_KEEP);
  endfunction

  function automatic logic is_legal_operation(input logic [FIELD_W-1:0] o);
    return (o <= OP_IS_ISOSCELES) || (o == OP_KEEP);
  endfunction

  // Operates on a resolved pair, so KEEP codes never reach here.
  function automatic logic is_legal_combination(input logic [FIELD_W-1:0] s,
                                                input logic [FIELD_W-1:0] o);
    logic ok;
    case (o)
      OP_PERIMETER, OP_AREA:              ok = 1'b1;
      OP_IS_SQUARE:                       ok = (s == SHAPE_RECTANGLE);
      OP_IS_EQUILATERAL, OP_IS_ISOSCELES: ok = (s == SHAPE_TRIANGLE);
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/shape_processor_bank_channel.sv
// One channel's ctrl register with KEEP resolution and accept decision.
// Optional shadow/active split under SHAPE_PROCESSOR_BANK_SHADOW_EN.
module shape_processor_bank_channel
  import shape_processor_bank_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_sel,
  input  logic [FIELD_W-1:0] wr_shape,
  input  logic [FIELD_W-1:0] wr_operation,
`ifdef SHAPE_PROCESSOR_BANK_SHADOW_EN
  input  logic               commit,
`endif
  output ctrl_t              active,
  output ctrl_t              rd_value,
  output logic               wr_reject_c
);

  localparam ctrl_t CTRL_RESET = '{operation: OP_PERIMETER, shape: SHAPE_CIRCLE};

  ctrl_t cur_q;
  ctrl_t res_c;
  logic  legal_c;
  logic  accept_c;

  // KEEP resolves against the register that writes land in.
  always_comb begin
    res_c.shape     = (wr_shape == SHAPE_KEEP) ? cur_q.shape : wr_shape;
    res_c.operation = (wr_operation == OP_KEEP) ? cur_q.operation : wr_operation;
    legal_c         = is_legal_shape(wr_shape) && is_legal_operation(wr_operation) &&
                      is_legal_combination(res_c.shape, res_c.operation);
    accept_c        = wr_sel && legal_c;
    wr_reject_c     = wr_sel && !legal_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cur_q <= CTRL_RESET;
    else if (accept_c) cur_q <= res_c;
  end

`ifdef SHAPE_PROCESSOR_BANK_SHADOW_EN
  ctrl_t active_q;

  // Commit copies the pre-write shadow; a same-cycle write lands in the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      active_q <= CTRL_RESET;
    else if (commit) active_q <= cur_q;
  end

  assign active = active_q;
`else
  assign active = cur_q;
`endif

  assign rd_value = cur_q;

endmodule

// File: rtl/shape_processor_bank.sv
// NUM_CH-channel shape/operation ctrl register bank with clear-on-read reject status.
// Optional shadow registers with commit port under SHAPE_PROCESSOR_BANK_SHADOW_EN.
module shape_processor_bank
  import shape_processor_bank_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned AW     = $clog2(NUM_CH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write,
  input  logic [AW-1:0]         write_addr,
  input  logic [DATA_W-1:0]     write_data,
  input  logic                  read,
  input  logic [AW-1:0]         read_addr,
  output logic [DATA_W-1:0]     read_data,
  output logic                  error,
  output logic [3*NUM_CH-1:0]   ctrl_shape,
  output logic [3*NUM_CH-1:0]   ctrl_operation
`ifdef SHAPE_PROCESSOR_BANK_SHADOW_EN
  ,
  input  logic                  commit
`endif
);

  ctrl_t             ch_active [NUM_CH];
  ctrl_t             ch_rd     [NUM_CH];
  logic [NUM_CH-1:0] ch_sel_c;
  logic [NUM_CH-1:0] ch_reject_c;
  logic              wr_is_ch_c;
  logic              wr_reject_c;
  logic              status_rd_c;
  logic [CNT_W-1:0]  cnt_q, cnt_base_c, cnt_nxt_c;
  logic [NUM_CH-1:0] sticky_q, sticky_base_c, sticky_nxt_c;
  logic [DATA_W-1:0] status_word_c;
  logic [DATA_W-1:0] rd_nxt_c;
  logic              unused_data_bits;

  assign unused_data_bits = ^{write_data[DATA_W-1:OP_LSB+FIELD_W], write_data[OP_LSB-1:FIELD_W]};

  assign wr_is_ch_c = (write_addr < AW'(NUM_CH));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_sel_c[i] = write && wr_is_ch_c && (write_addr == AW'(i));

    shape_processor_bank_channel u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_sel       (ch_sel_c[i]),
      .wr_shape     (write_data[SHAPE_LSB +: FIELD_W]),
      .wr_operation (write_data[OP_LSB +: FIELD_W]),
`ifdef SHAPE_PROCESSOR_BANK_SHADOW_EN
      .commit       (commit),
`endif
      .active       (ch_active[i]),
      .rd_value     (ch_rd[i]),
      .wr_reject_c  (ch_reject_c[i])
    );

    assign ctrl_shape[3*i +: 3]     = ch_active[i].shape;
    assign ctrl_operation[3*i +: 3] = ch_active[i].operation;
  end

  assign wr_reject_c = write && (!wr_is_ch_c || (|ch_reject_c));
  assign status_rd_c = read && (read_addr == AW'(NUM_CH));

  // A reject in the same cycle as a status read lands on the cleared value.
  always_comb begin
    cnt_base_c    = status_rd_c ? '0 : cnt_q;
    sticky_base_c = status_rd_c ? '0 : sticky_q;
    cnt_nxt_c     = cnt_base_c;
    sticky_nxt_c  = sticky_base_c;
    if (wr_reject_c) begin
      cnt_nxt_c    = (cnt_base_c == '1) ? cnt_base_c : cnt_base_c + CNT_W'(1);
      sticky_nxt_c = sticky_base_c | ch_reject_c;
    end
  end

  always_comb begin
    status_word_c                          = '0;
    status_word_c[CNT_W-1:0]               = cnt_q;
    status_word_c[STICKY_LSB +: NUM_CH]    = sticky_q;
  end

  // Read mux; out-of-range reads return zero, no read holds.
  always_comb begin
    rd_nxt_c = read_data;
    if (read) begin
      rd_nxt_c = '0;
      if (status_rd_c) rd_nxt_c = status_word_c;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (read_addr == AW'(i))
          rd_nxt_c = {25'b0, ch_rd[i].operation, 1'b0, ch_rd[i].shape};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data <= '0;
      error     <= 1'b0;
      cnt_q     <= '0;
      sticky_q  <= '0;
    end else begin
      read_data <= rd_nxt_c;
      error     <= wr_reject_c;
      cnt_q     <= cnt_nxt_c;
      sticky_q  <= sticky_nxt_c;
    end
  end

endmodule

// File: tb/tb_shape_processor_bank.sv
// Directed self-checking bench for shape_processor_bank (NUM_CH=4).
// Exercises the shadow/commit path when SHAPE_PROCESSOR_BANK_SHADOW_EN is defined.
module tb_shape_processor_bank;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned AW     = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              write;
  logic [AW-1:0]     write_addr;
  logic [31:0]       write_data;
  logic              read;
  logic [AW-1:0]     read_addr;
  logic [31:0]       read_data;
  logic              error;
  logic [3*NUM_CH-1:0] ctrl_shape;
  logic [3*NUM_CH-1:0] ctrl_operation;
`ifdef SHAPE_PROCESSOR_BANK_SHADOW_EN
  logic              commit = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  shape_processor_bank #(.NUM_CH(NUM_CH), .AW(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .write          (write),
    .write_addr     (write_addr),
    .write_data     (write_data),
    .read           (read),
    .read_addr      (read_addr),
    .read_data      (read_data),
    .error          (error),
    .ctrl_shape     (ctrl_shape),
    .ctrl_operation (ctrl_operation)
`ifdef SHAPE_PROCESSOR_BANK_SHADOW_EN
    ,
    .commit         (commit)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    write = 1'b1; write_addr = a; write_data = d;
    step();
    write = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    read = 1'b1; read_addr = a;
    step();
    read = 1'b0;
  endtask

  // Makes the active registers reflect the latest writes in the shadow build.
  task automatic sync_active();
`ifdef SHAPE_PROCESSOR_BANK_SHADOW_EN
    commit = 1'b1;
    step();
    commit = 1'b0;
`endif
  endtask

  initial begin
    rst_n = 1'b0; write = 1'b0; write_addr = '0; write_data = '0;
    read = 1'b0; read_addr = '0;
    repeat (3) step();
    check("reset_read_data", read_data, 32'h0);
    check("reset_error", 32'(error), 32'h0);
    check("reset_shape", 32'(ctrl_shape), 32'h0);
    check("reset_operation", 32'(ctrl_operation), 32'h0);
    rst_n = 1'b1;
    step();

    // ch1 <- TRIANGLE/AREA
    wr(3'd1, 32'h12);
    check("ch1_write_error", 32'(error), 32'h0);
    sync_active();
    check("ch1_shape", 32'(ctrl_shape[5:3]), 32'd2);
    check("ch1_operation", 32'(ctrl_operation[5:3]), 32'd1);
    rd(3'd1);
    check("ch1_read", read_data, 32'h12);

    // ch0 <- TRIANGLE/IS_EQUILATERAL, then CIRCLE with KEEP op is illegal
    wr(3'd0, 32'h32);
    check("ch0_legal_error", 32'(error), 32'h0);
    wr(3'd0, 32'h70);
    check("ch0_keep_reject_error", 32'(error), 32'h1);
    step();
    check("error_single_pulse", 32'(error), 32'h0);
    rd(3'd0);
    check("ch0_unchanged", read_data, 32'h32);
    rd(3'd4);
    check("status_after_keep_reject", read_data, 32'h0001_0001);
    rd(3'd4);
    check("status_cleared_on_read", read_data, 32'h0);

    // ch2 <- RECTANGLE/IS_SQUARE, then full KEEP no-op
    wr(3'd2, 32'h21);
    check("ch2_write_error", 32'(error), 32'h0);
    wr(3'd2, 32'h77);
    check("ch2_keep_both_error", 32'(error), 32'h0);
    rd(3'd2);
    check("ch2_read", read_data, 32'h21);

    // Illegal shape, illegal operation, address-class rejects
    wr(3'd1, 32'h03);
    check("ch1_bad_shape_error", 32'(error), 32'h1);
    rd(3'd4);
    check("status_bad_shape", read_data, 32'h0002_0001);
    wr(3'd1, 32'h52);
    check("ch1_bad_op_error", 32'(error), 32'h1);
    wr(3'd4, 32'h00);
    check("status_addr_write_error", 32'(error), 32'h1);
    wr(3'd6, 32'h00);
    check("oor_write_error", 32'(error), 32'h1);
    rd(3'd4);
    check("status_addr_class_no_sticky", read_data, 32'h0002_0003);
    rd(3'd5);
    check("oor_read_zero", read_data, 32'h0);
    rd(3'd1);
    check("ch1_after_rejects", read_data, 32'h12);
    step();
    check("read_data_holds", read_data, 32'h12);

    // Same-cycle read and write of ch1 returns the pre-write value
    write = 1'b1; write_addr = 3'd1; write_data = 32'h11;
    read = 1'b1; read_addr = 3'd1;
    step();
    write = 1'b0; read = 1'b0;
    check("rw_same_ch_pre_write", read_data, 32'h12);
    sync_active();
    check("all_shapes", 32'(ctrl_shape), 32'h04A);
    check("all_operations", 32'(ctrl_operation), 32'h08B);

    // Back-to-back: KEEP shape resolves against the previous cycle's write
    wr(3'd3, 32'h02);
    check("b2b_first_error", 32'(error), 32'h0);
    wr(3'd3, 32'h37);
    check("b2b_keep_error", 32'(error), 32'h0);
    rd(3'd3);
    check("b2b_keep_result", read_data, 32'h32);
    wr(3'd3, 32'h00);
    check("ch3_restore_error", 32'(error), 32'h0);

    // 65537 illegal writes to ch3 saturate the count
    write = 1'b1; write_addr = 3'd3; write_data = 32'h05;
    repeat (65537) @(posedge clk);
    #1;
    check("sat_error_high", 32'(error), 32'h1);
    // Status read alongside an illegal ch1 write
    write_addr = 3'd1;
    read = 1'b1; read_addr = 3'd4;
    step();
    write = 1'b0; read = 1'b0;
    check("status_saturated", read_data, 32'h0008_FFFF);
    rd(3'd4);
    check("status_new_error_wins", read_data, 32'h0002_0001);

    // Asynchronous reset mid-operation
    write = 1'b1; write_addr = 3'd2; write_data = 32'h05;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_read_data", read_data, 32'h0);
    check("async_rst_shape", 32'(ctrl_shape), 32'h0);
    check("async_rst_operation", 32'(ctrl_operation), 32'h0);
    check("async_rst_error", 32'(error), 32'h0);
    write = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    rd(3'd4);
    check("async_rst_status", read_data, 32'h0);

`ifdef SHAPE_PROCESSOR_BANK_SHADOW_EN
    wr(3'd0, 32'h11);
    check("shadow_pre_commit_shape", 32'(ctrl_shape[2:0]), 32'd0);
    rd(3'd0);
    check("shadow_read", read_data, 32'h11);
    commit = 1'b1;
    step();
    commit = 1'b0;
    check("shadow_post_commit_shape", 32'(ctrl_shape[2:0]), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
